// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: walks (digit, phase) slots,
// latches each digit's data at slot start and drives registered anode/segment outputs.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 4,
  localparam int SEL_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1,
  localparam int PH_W  = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1
) (
  input  logic                    clk16,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] hex_data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [PH_W-1:0]         on_cycles,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [SEL_W-1:0]        digit_sel,
  output logic                    frame_start
);

  localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(SLOT_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
  localparam logic [SEL_W-1:0] DIG_MAX = SEL_W'(NUM_DIGITS - 1);
  localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);
  localparam logic [31:0]      SLOT_U  = 32'(SLOT_CYCLES);

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h40;  4'h1: r = 7'h79;  4'h2: r = 7'h24;  4'h3: r = 7'h30;
      4'h4: r = 7'h19;  4'h5: r = 7'h12;  4'h6: r = 7'h02;  4'h7: r = 7'h78;
      4'h8: r = 7'h00;  4'h9: r = 7'h10;  4'hA: r = 7'h08;  4'hB: r = 7'h03;
      4'hC: r = 7'h46;  4'hD: r = 7'h21;  4'hE: r = 7'h06;  4'hF: r = 7'h0E;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  logic [SEL_W-1:0]      digit_q, digit_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [3:0]            lat_hex_q, lat_hex_d;
  logic                  lat_dp_q, lat_dp_d;
  logic                  lat_en_q, lat_en_d;
  logic [PH_W-1:0]       lat_on_q, lat_on_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic                  frame_start_q, frame_start_d;

  logic                  slot_start;
  logic [3:0]            hex_pick;
  logic                  dp_pick;
  logic                  en_pick;
  logic [31:0]           on_ext;
  logic [31:0]           eff;
  logic                  lit;

  // Next state, slot-start latch and next registered outputs.
  always_comb begin
    digit_d       = digit_q;
    phase_d       = phase_q;
    lat_hex_d     = lat_hex_q;
    lat_dp_d      = lat_dp_q;
    lat_en_d      = lat_en_q;
    lat_on_d      = lat_on_q;
    hex_pick      = 4'h0;
    dp_pick       = 1'b0;
    en_pick       = 1'b0;
    an_d          = '1;
    seg_d         = 7'h7F;
    dp_n_d        = 1'b1;
    frame_start_d = 1'b0;

    if (!reset) begin
      digit_d = '0;
      phase_d = '0;
    end else if (phase_q == PH_MAX) begin
      phase_d = '0;
      digit_d = (digit_q == DIG_MAX) ? '0 : digit_q + SEL_ONE;
    end else begin
      phase_d = phase_q + PH_ONE;
    end

    for (int d = 0; d < NUM_DIGITS; d++) begin
      hex_pick = hex_pick | ((digit_d == SEL_W'(d)) ? hex_data[4*d +: 4] : 4'h0);
      dp_pick  = dp_pick  | ((digit_d == SEL_W'(d)) ? dp[d]       : 1'b0);
      en_pick  = en_pick  | ((digit_d == SEL_W'(d)) ? digit_en[d] : 1'b0);
    end

    // Reset also counts as a slot start so digit 0's first slot has valid data.
    slot_start = (phase_d == '0);
    if (slot_start) begin
      lat_hex_d = hex_pick;
      lat_dp_d  = dp_pick;
      lat_en_d  = en_pick;
      lat_on_d  = on_cycles;
    end else begin
      lat_hex_d = lat_hex_q;
      lat_dp_d  = lat_dp_q;
      lat_en_d  = lat_en_q;
      lat_on_d  = lat_on_q;
    end

    // Lit window is the tail of the slot; eff <= SLOT_CYCLES-1 keeps phase 0 dark.
    on_ext = 32'(lat_on_d);
    eff    = (on_ext > SLOT_U - 32'd1) ? SLOT_U - 32'd1 : on_ext;
    lit    = lat_en_d & (32'(phase_d) >= SLOT_U - eff);

    if (!reset) begin
      an_d          = '1;
      seg_d         = 7'h7F;
      dp_n_d        = 1'b1;
      frame_start_d = 1'b0;
    end else begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        an_d[d] = ~(lit & (digit_d == SEL_W'(d)));
      end
      seg_d         = seg_decode(lat_hex_d);
      dp_n_d        = ~lat_dp_d;
      frame_start_d = (digit_d == '0) & (phase_d == '0);
    end
  end

  // State and output registers; synchronous reset is folded into the _d terms.
  always_ff @(posedge clk16) begin
    digit_q       <= digit_d;
    phase_q       <= phase_d;
    lat_hex_q     <= lat_hex_d;
    lat_dp_q      <= lat_dp_d;
    lat_en_q      <= lat_en_d;
    lat_on_q      <= lat_on_d;
    an_q          <= an_d;
    seg_q         <= seg_d;
    dp_n_q        <= dp_n_d;
    frame_start_q <= frame_start_d;
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign digit_sel   = digit_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: table vectors, scoreboard streams and
// hand sequences on a 4x4 instance and a 3x5 instance.
module tb_seg_scan_ctrl;

  logic clk16 = 1'b0;
  always #5 clk16 = ~clk16;

  logic        reset_a;
  logic [15:0] hex_a;
  logic [3:0]  dp_a, en_a;
  logic [1:0]  on_a;
  logic [3:0]  an_a;
  logic [6:0]  seg_a;
  logic        dpn_a;
  logic [1:0]  sel_a;
  logic        fs_a;

  logic        reset_b;
  logic [11:0] hex_b;
  logic [2:0]  dp_b, en_b;
  logic [2:0]  on_b;
  logic [2:0]  an_b;
  logic [6:0]  seg_b;
  logic        dpn_b;
  logic [1:0]  sel_b;
  logic        fs_b;

  seg_scan_ctrl u_dut_a (
    .clk16(clk16), .reset(reset_a), .hex_data(hex_a), .dp(dp_a), .digit_en(en_a),
    .on_cycles(on_a), .an(an_a), .seg(seg_a), .dp_n(dpn_a), .digit_sel(sel_a),
    .frame_start(fs_a)
  );

  seg_scan_ctrl #(.NUM_DIGITS(3), .SLOT_CYCLES(5)) u_dut_b (
    .clk16(clk16), .reset(reset_b), .hex_data(hex_b), .dp(dp_b), .digit_en(en_b),
    .on_cycles(on_b), .an(an_b), .seg(seg_b), .dp_n(dpn_b), .digit_sel(sel_b),
    .frame_start(fs_b)
  );

  localparam logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic [2:0] sel;
    logic       fs;
  } exp_t;

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [1:0]  on;
    int          d;
    int          ph;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Expected anode vector from the brightness rule, nd bits wide.
  function automatic logic [7:0] exp_an(input int nd, input int slot, input int d,
                                        input int ph, input logic [7:0] en, input int on);
    logic [7:0] r;
    int eff;
    r   = 8'((9'd1 << nd) - 9'd1);
    eff = (on > slot - 1) ? slot - 1 : on;
    if (en[d] && (ph >= slot - eff)) r[d] = 1'b0;
    return r;
  endfunction

  task automatic pop_check_a(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty at %0t", tag, $time);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".an"},  32'(an_a),  32'(e.an[3:0]));
      chk({tag, ".seg"}, 32'(seg_a), 32'(e.seg));
      chk({tag, ".dpn"}, 32'(dpn_a), 32'(e.dp_n));
      chk({tag, ".sel"}, 32'(sel_a), 32'(e.sel[1:0]));
      chk({tag, ".fs"},  32'(fs_a),  32'(e.fs));
    end
  endtask

  task automatic apply_a(input logic [15:0] h, input logic [3:0] p, input logic [3:0] e,
                         input logic [1:0] o);
    @(negedge clk16);
    reset_a = 1'b0;
    hex_a = h; dp_a = p; en_a = e; on_a = o;
    @(negedge clk16);
    reset_a = 1'b1;
  endtask

  task automatic apply_b(input logic [11:0] h, input logic [2:0] p, input logic [2:0] e,
                         input logic [2:0] o);
    @(negedge clk16);
    reset_b = 1'b0;
    hex_b = h; dp_b = p; en_b = e; on_b = o;
    @(negedge clk16);
    reset_b = 1'b1;
  endtask

  // Run n cycles after release on instance A, predicting every cycle.
  task automatic stream_a(input logic [15:0] h, input logic [3:0] p, input logic [3:0] e,
                          input logic [1:0] o, input int n);
    exp_t x;
    int pos, d, ph;
    apply_a(h, p, e, o);
    for (int k = 1; k <= n; k++) begin
      pos    = k % 16;
      d      = pos / 4;
      ph     = pos % 4;
      x.an   = exp_an(4, 4, d, ph, 8'(e), int'(o));
      x.seg  = SEG_REF[h[4*d +: 4]];
      x.dp_n = ~p[d];
      x.sel  = 3'(d);
      x.fs   = (pos == 0);
      sb_q.push_back(x);
      @(negedge clk16);
      pop_check_a("stream_a");
    end
  endtask

  initial begin
    vec_t v;
    exp_t x;
    int pos, d, ph;

    reset_a = 1'b0; hex_a = 16'h4321; dp_a = 4'h0; en_a = 4'hF; on_a = 2'd1;
    reset_b = 1'b0; hex_b = 12'h5A3;  dp_b = 3'b010; en_b = 3'b101; on_b = 3'd7;
    repeat (3) @(negedge clk16);

    chk("rst_a.an",  32'(an_a),  32'h0000000F);
    chk("rst_a.seg", 32'(seg_a), 32'h0000007F);
    chk("rst_a.dpn", 32'(dpn_a), 32'h00000001);
    chk("rst_a.sel", 32'(sel_a), 32'h00000000);
    chk("rst_a.fs",  32'(fs_a),  32'h00000000);
    chk("rst_b.an",  32'(an_b),  32'h00000007);
    chk("rst_b.seg", 32'(seg_b), 32'h0000007F);

    vecs.push_back('{16'h4321, 4'h0, 4'hF, 2'd1, 0, 3, 4'hE, 7'h79, 1'b1});
    vecs.push_back('{16'h4321, 4'h0, 4'hF, 2'd1, 1, 3, 4'hD, 7'h24, 1'b1});
    vecs.push_back('{16'h4321, 4'h0, 4'hF, 2'd1, 0, 2, 4'hF, 7'h79, 1'b1});
    vecs.push_back('{16'h4321, 4'h0, 4'hF, 2'd3, 2, 1, 4'hB, 7'h30, 1'b1});
    vecs.push_back('{16'h4321, 4'h0, 4'hF, 2'd3, 3, 0, 4'hF, 7'h19, 1'b1});
    vecs.push_back('{16'h4321, 4'h0, 4'hF, 2'd0, 2, 3, 4'hF, 7'h30, 1'b1});
    vecs.push_back('{16'h4321, 4'h0, 4'h5, 2'd3, 1, 2, 4'hF, 7'h24, 1'b1});
    vecs.push_back('{16'h4321, 4'h0, 4'h5, 2'd3, 2, 2, 4'hB, 7'h30, 1'b1});
    vecs.push_back('{16'hCBA9, 4'h2, 4'hF, 2'd2, 1, 2, 4'hD, 7'h08, 1'b0});
    vecs.push_back('{16'hCBA9, 4'h2, 4'hF, 2'd2, 1, 1, 4'hF, 7'h08, 1'b0});
    vecs.push_back('{16'hCBA9, 4'h2, 4'hF, 2'd2, 0, 0, 4'hF, 7'h10, 1'b1});
    vecs.push_back('{16'h4321, 4'h8, 4'hF, 2'd3, 3, 3, 4'h7, 7'h19, 1'b0});
    for (int n = 0; n < 16; n++) begin
      vecs.push_back('{{4{4'(n)}}, 4'h0, 4'hF, 2'd3, 0, 1, 4'hE, SEG_REF[n], 1'b1});
    end

    foreach (vecs[i]) begin
      v      = vecs[i];
      x.an   = {4'h0, v.an};
      x.seg  = v.seg;
      x.dp_n = v.dp_n;
      x.sel  = 3'(v.d);
      x.fs   = (v.d == 0) && (v.ph == 0);
      sb_q.push_back(x);
      apply_a(v.hex, v.dp, v.en, v.on);
      repeat (16 + 4 * v.d + v.ph) @(negedge clk16);
      pop_check_a($sformatf("vec%0d", i));
    end

    stream_a(16'h4321, 4'h0, 4'hF, 2'd1, 36);
    stream_a(16'h4321, 4'h0, 4'h5, 2'd3, 36);
    stream_a(16'hA5F0, 4'h9, 4'hF, 2'd2, 20);
    stream_a(16'h4321, 4'h0, 4'hF, 2'd0, 20);

    // Mid-slot data change must wait for the next slot.
    apply_a(16'h0000, 4'h0, 4'hF, 2'd1);
    repeat (6) @(negedge clk16);
    chk("hold.seg_d1p2", 32'(seg_a), 32'h00000040);
    hex_a = 16'hFFFF;
    @(negedge clk16);
    chk("hold.seg_d1p3", 32'(seg_a), 32'h00000040);
    chk("hold.an_d1p3",  32'(an_a),  32'h0000000D);
    @(negedge clk16);
    chk("hold.seg_d2p0", 32'(seg_a), 32'h0000000E);
    chk("hold.an_d2p0",  32'(an_a),  32'h0000000F);

    // Mid-slot reset on instance A, then release enters (0,1).
    apply_a(16'h4321, 4'h0, 4'hF, 2'd3);
    repeat (11) @(negedge clk16);
    chk("midrst_a.pre_an", 32'(an_a), 32'h0000000B);
    reset_a = 1'b0;
    @(negedge clk16);
    chk("midrst_a.an",  32'(an_a),  32'h0000000F);
    chk("midrst_a.seg", 32'(seg_a), 32'h0000007F);
    chk("midrst_a.dpn", 32'(dpn_a), 32'h00000001);
    chk("midrst_a.sel", 32'(sel_a), 32'h00000000);
    chk("midrst_a.fs",  32'(fs_a),  32'h00000000);
    reset_a = 1'b1;
    @(negedge clk16);
    chk("midrst_a.rel_an",  32'(an_a),  32'h0000000E);
    chk("midrst_a.rel_seg", 32'(seg_a), 32'h00000079);

    // Instance B: 3 digits x 5 cycles, saturating brightness.
    apply_b(12'h5A3, 3'b010, 3'b101, 3'd7);
    for (int k = 1; k <= 32; k++) begin
      pos    = k % 15;
      d      = pos / 5;
      ph     = pos % 5;
      x.an   = exp_an(3, 5, d, ph, 8'(en_b), int'(on_b));
      x.seg  = SEG_REF[hex_b[4*d +: 4]];
      x.dp_n = ~dp_b[d];
      x.sel  = 3'(d);
      x.fs   = (pos == 0);
      sb_q.push_back(x);
      @(negedge clk16);
      x = sb_q.pop_front();
      chk("stream_b.an",  32'(an_b),  32'(x.an[2:0]));
      chk("stream_b.seg", 32'(seg_b), 32'(x.seg));
      chk("stream_b.dpn", 32'(dpn_b), 32'(x.dp_n));
      chk("stream_b.sel", 32'(sel_b), 32'(x.sel[1:0]));
      chk("stream_b.fs",  32'(fs_b),  32'(x.fs));
    end

    apply_b(12'h5A3, 3'b010, 3'b101, 3'd7);
    repeat (13) @(negedge clk16);
    chk("midrst_b.pre_sel", 32'(sel_b), 32'h00000002);
    chk("midrst_b.pre_an",  32'(an_b),  32'h00000003);
    reset_b = 1'b0;
    @(negedge clk16);
    chk("midrst_b.an",  32'(an_b),  32'h00000007);
    chk("midrst_b.seg", 32'(seg_b), 32'h0000007F);
    chk("midrst_b.dpn", 32'(dpn_b), 32'h00000001);
    chk("midrst_b.sel", 32'(sel_b), 32'h00000000);
    chk("midrst_b.fs",  32'(fs_b),  32'h00000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, meaning: number of multiplexed digits; legal range 2..8.
REQ-002 Parameter SLOT_CYCLES, default 4, meaning: clk16 cycles per digit time slot; legal range 2..65536.
REQ-003 Derived SEL_W = max(1, clog2(NUM_DIGITS)); PH_W = max(1, clog2(SLOT_CYCLES)).
REQ-004 clk16  input  1  scan clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low; reset asserted when 0.
REQ-006 hex_data  input  4*NUM_DIGITS  nibble d = hex_data[4d+3:4d] is the value for digit d.
REQ-007 dp  input  NUM_DIGITS  bit d = 1 lights the decimal point of digit d.
REQ-008 digit_en  input  NUM_DIGITS  bit d = 0 keeps digit d dark for its slot.
REQ-009 on_cycles  input  PH_W  lit cycles per slot (brightness).
REQ-010 an  output  NUM_DIGITS  anode drives, active-low; an[d] belongs to digit d.
REQ-011 seg  output  7  segments, active-low; seg[6:0] = g,f,e,d,c,b,a.
REQ-012 dp_n  output  1  decimal point, active-low.
REQ-013 digit_sel  output  SEL_W  index of the digit owning the current slot.
REQ-014 frame_start  output  1  one-cycle pulse marking the first cycle of a frame.

Function
REQ-015 Internal state SHALL be (digit, phase): phase 0..SLOT_CYCLES-1; digit 0..NUM_DIGITS-1.
REQ-016 Each edge with reset=1 SHALL increment phase; phase wraps to 0 after SLOT_CYCLES-1 and digit then increments.
REQ-017 Digit SHALL wrap from NUM_DIGITS-1 to 0; frame length = NUM_DIGITS*SLOT_CYCLES cycles, including non-power-of-2 NUM_DIGITS.
REQ-018 All outputs SHALL be registered and reflect the state entered on the same edge; no combinational input-to-output path.
REQ-019 Slot-start latch: on each edge entering phase 0, or during reset, hex_data nibble, dp bit, and digit_en bit of the new digit SHALL be captured, together with on_cycles.
REQ-020 Latched values SHALL hold for the whole slot; input changes mid-slot SHALL have no effect until the next slot.
REQ-021 Brightness: eff = min(on_cycles_latched, SLOT_CYCLES-1).
REQ-022 an[digit] SHALL be 0 exactly when latched enable = 1 and phase >= SLOT_CYCLES-eff.
REQ-023 Every other an bit SHALL be 1; at most one an bit SHALL be 0 in any cycle.
REQ-024 Phase 0 SHALL always be dark (all an = 1); seg and dp_n change only on entering phase 0.
REQ-025 on_cycles = 0 SHALL keep all anodes high for the slot; a disabled digit still consumes its slot.
REQ-026 Decode, seg hex: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78.
REQ-027 Decode, seg hex continued: 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-028 dp_n SHALL be the inverse of the latched dp bit.
REQ-029 digit_sel SHALL equal the current digit for every cycle of that slot.
REQ-030 frame_start SHALL be 1 only in cycles with state (0,0) and reset = 1 on the preceding edge.

Reset
REQ-031 An edge with reset=0 SHALL force state (0,0), an = all 1, seg = 7F, dp_n = 1, digit_sel = 0, frame_start = 0.
REQ-032 Reset SHALL take precedence over all events, including mid-slot and mid-frame.
REQ-033 First edge with reset=1 SHALL enter (0,1); first frame_start SHALL occur NUM_DIGITS*SLOT_CYCLES edges after release.

Verification
REQ-034 Defaults, hex_data=4321, dp=0, digit_en=F, on_cycles=1 -> an=E during phase 3 of digit 0 only, seg=79; an=D at digit 1 phase 3 with seg=24; repeats every 16 cycles.
REQ-035 on_cycles=3 (and separately 7) -> each digit lit in phases 1..3, never phase 0; on_cycles=0 -> an stays F.
REQ-036 digit_en=5 -> only an[0] and an[2] pulse; frame period remains 16 cycles; digit_sel still counts 0,1,2,3.
REQ-037 Change hex_data from 0000 to FFFF at digit 1 phase 2 -> seg stays 40 until the edge entering digit 2 phase 0, then 0E; never changes while an is low.
REQ-038 NUM_DIGITS=3, SLOT_CYCLES=5 -> digit_sel 0,1,2 wraps to 0; frame_start period 15; reset=0 at digit 2 phase 3 -> next cycle an=7 (all high), seg=7F, digit_sel=0.
